// File: rtl/arinc_sched_pkg.sv
// Shared types and constants for the ARINC-429 periodic TX label scheduler.
package arinc_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_e;

    localparam logic CFG_WORD   = 1'b0;
    localparam logic CFG_PERIOD = 1'b1;

    localparam int unsigned PERIOD_W = 16;

endpackage

// File: rtl/arinc_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, wrapping past the top.
module arinc_rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] idx;

    // N is a power of two, so the IW-bit add wraps naturally.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + IW'(k);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/arinc_tx_scheduler.sv
// Periodic label scheduler for one ARINC-429 TX channel: per-entry ms countdowns raise
// pending requests that a round-robin FSM pushes into the transmitter FIFO.
module arinc_tx_scheduler
    import arinc_sched_pkg::*;
#(
    parameter int unsigned ENTRIES        = 8,
    parameter int unsigned INPUTFREQUENCY = 62_500_000,
    parameter int unsigned TICK_CYCLES    = INPUTFREQUENCY / 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [$clog2(ENTRIES)-1:0] cfg_addr,
    input  logic [31:0]                cfg_wdata,
    input  logic [ENTRIES-1:0]         ovr_clr,
    input  logic                       tx_full,
    output logic                       tx_wr,
    output logic [31:0]                tx_data,
    output logic [ENTRIES-1:0]         overrun,
    output logic                       IRQ
);

    localparam int unsigned AW = $clog2(ENTRIES);
    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [PW-1:0]       presc_q;
    logic                tick;

    logic [31:0]         word_q   [ENTRIES];
    logic [PERIOD_W-1:0] period_q [ENTRIES];
    logic [PERIOD_W-1:0] cnt_q    [ENTRIES];
    logic [ENTRIES-1:0]  pending_q;
    logic [ENTRIES-1:0]  overrun_q;

    logic [ENTRIES-1:0]  word_wr;
    logic [ENTRIES-1:0]  period_wr;
    logic [ENTRIES-1:0]  expire;
    logic [ENTRIES-1:0]  grant;
    logic [ENTRIES-1:0]  ovr_set;

    state_e              state_q;
    logic [AW-1:0]       rr_q;
    logic                gnt_valid;
    logic [AW-1:0]       gnt_idx;
    logic                take;

    // 1 ms prescaler; held at zero while stopped so a restart gives a full first tick.
    assign tick = enable && (presc_q == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else if (!enable || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    arinc_rr_arbiter #(
        .N (ENTRIES)
    ) u_arb (
        .req       (pending_q),
        .ptr       (rr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign take = (state_q == IDLE) && enable && !tx_full && gnt_valid;

    always_comb begin
        word_wr   = '0;
        period_wr = '0;
        expire    = '0;
        grant     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            word_wr[i]   = cfg_we && (cfg_sel == CFG_WORD) && (cfg_addr == AW'(i));
            period_wr[i] = cfg_we && (cfg_sel == CFG_PERIOD) && (cfg_addr == AW'(i));
            expire[i]    = tick && (period_q[i] != '0) && (cnt_q[i] <= PERIOD_W'(1));
            grant[i]     = take && (gnt_idx == AW'(i));
        end
    end

    // A request landing on an entry being granted this cycle is a fresh request, not an overrun.
    assign ovr_set = expire & pending_q & ~grant & ~period_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                word_q[i]   <= '0;
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            overrun_q <= (overrun_q & ~ovr_clr) | ovr_set;
            for (int i = 0; i < ENTRIES; i++) begin
                if (word_wr[i]) begin
                    word_q[i] <= cfg_wdata;
                end
                if (period_wr[i]) begin
                    period_q[i]  <= cfg_wdata[PERIOD_W-1:0];
                    cnt_q[i]     <= cfg_wdata[PERIOD_W-1:0];
                    pending_q[i] <= 1'b0;
                end else if (period_q[i] == '0) begin
                    cnt_q[i]     <= '0;
                    pending_q[i] <= 1'b0;
                end else if (!enable) begin
                    pending_q[i] <= 1'b0;
                end else if (expire[i]) begin
                    cnt_q[i]     <= period_q[i];
                    pending_q[i] <= 1'b1;
                end else begin
                    if (tick) begin
                        cnt_q[i] <= cnt_q[i] - 1'b1;
                    end
                    if (grant[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_wr   <= 1'b0;
            tx_data <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_wr <= 1'b0;
                    if (take) begin
                        tx_data <= word_q[gnt_idx];
                        rr_q    <= gnt_idx + 1'b1;
                        tx_wr   <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_wr   <= 1'b0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    tx_wr   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_wr   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign overrun = overrun_q;
    assign IRQ     = |overrun_q;

endmodule

// File: tb/tb_arinc_tx_scheduler.sv
// Directed bench for arinc_tx_scheduler: expected writes (word + cycle) are queued by the
// stimulus and a negedge monitor pops and compares each tx_wr strobe.
module tb_arinc_tx_scheduler;
    import arinc_sched_pkg::*;

    localparam int unsigned ENTRIES = 8;

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_we;
    logic        cfg_sel;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [7:0]  ovr_clr;
    logic        tx_full;
    logic        tx_wr;
    logic [31:0] tx_data;
    logic [7:0]  overrun;
    logic        irq;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   c0;
    int   c1;
    exp_t exp_q[$];
    exp_t mon_e;

    arinc_tx_scheduler #(
        .ENTRIES        (ENTRIES),
        .INPUTFREQUENCY (10_000),
        .TICK_CYCLES    (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .ovr_clr   (ovr_clr),
        .tx_full   (tx_full),
        .tx_wr     (tx_wr),
        .tx_data   (tx_data),
        .overrun   (overrun),
        .IRQ       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_wr === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_tx: got %h at cycle %0d, required no write", tx_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_data !== mon_e.data || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL tx_word: got %h @%0d, required %h @%0d",
                             tx_data, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_tx(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic sel, input logic [2:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        cfg_we  = 1'b0;
        tx_full = 1'b0;
        ovr_clr = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; ovr_clr = '0; tx_full = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_tx_wr", 32'(tx_wr), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // 1: single entry, period 3 ms -> one write every 30 clk
        do_reset();
        cfg(CFG_WORD, 3'd0, 32'h0000_00A1);
        cfg(CFG_PERIOD, 3'd0, 32'd3);
        enable = 1'b1; c0 = cyc;
        expect_tx(32'h0000_00A1, c0 + 31);
        expect_tx(32'h0000_00A1, c0 + 61);
        goto(c0 + 70);
        enable = 1'b0;
        drained("t1_drained");

        // 2: entries 1,2,5 at 1 ms and entry 6 at 2 ms; round-robin resumes after last grant
        do_reset();
        cfg(CFG_WORD, 3'd1, 32'h0000_00B1);
        cfg(CFG_WORD, 3'd2, 32'h0000_00B2);
        cfg(CFG_WORD, 3'd5, 32'h0000_00B5);
        cfg(CFG_WORD, 3'd6, 32'h0000_00B6);
        cfg(CFG_PERIOD, 3'd1, 32'd1);
        cfg(CFG_PERIOD, 3'd2, 32'd1);
        cfg(CFG_PERIOD, 3'd5, 32'd1);
        cfg(CFG_PERIOD, 3'd6, 32'd2);
        enable = 1'b1; c0 = cyc;
        expect_tx(32'h0000_00B1, c0 + 11);
        expect_tx(32'h0000_00B2, c0 + 14);
        expect_tx(32'h0000_00B5, c0 + 17);
        expect_tx(32'h0000_00B6, c0 + 21);
        expect_tx(32'h0000_00B1, c0 + 24);
        expect_tx(32'h0000_00B2, c0 + 27);
        expect_tx(32'h0000_00B5, c0 + 30);
        expect_tx(32'h0000_00B1, c0 + 33);
        expect_tx(32'h0000_00B2, c0 + 36);
        expect_tx(32'h0000_00B5, c0 + 39);
        goto(c0 + 40);
        enable = 1'b0;
        goto(c0 + 48);
        chk("t2_no_overrun", 32'(overrun), 32'd0);
        drained("t2_drained");

        // 3: FIFO full for 25 clk -> overrun, then exactly one write, then W1C
        do_reset();
        cfg(CFG_WORD, 3'd3, 32'h0000_00C3);
        cfg(CFG_PERIOD, 3'd3, 32'd1);
        tx_full = 1'b1;
        enable = 1'b1; c0 = cyc;
        goto(c0 + 21);
        chk("t3_overrun_set", 32'(overrun), 32'h08);
        chk("t3_irq_set", 32'(irq), 32'd1);
        expect_tx(32'h0000_00C3, c0 + 26);
        goto(c0 + 25);
        tx_full = 1'b0;
        goto(c0 + 27);
        enable = 1'b0;
        goto(c0 + 30);
        chk("t3_overrun_kept", 32'(overrun), 32'h08);
        ovr_clr = 8'h08;
        @(posedge clk);
        #1;
        ovr_clr = '0;
        chk("t3_overrun_clr", 32'(overrun), 32'd0);
        chk("t3_irq_clr", 32'(irq), 32'd0);
        drained("t3_drained");

        // 4: period write on the tick cycle wins; no send on that tick
        do_reset();
        cfg(CFG_WORD, 3'd4, 32'h0000_00D4);
        cfg(CFG_PERIOD, 3'd4, 32'd1);
        enable = 1'b1; c0 = cyc;
        goto(c0 + 9);
        cfg(CFG_PERIOD, 3'd4, 32'd3);
        expect_tx(32'h0000_00D4, c0 + 41);
        goto(c0 + 45);
        enable = 1'b0;
        drained("t4_drained");

        // 5: period cleared while pending -> never sent, no overrun
        do_reset();
        cfg(CFG_WORD, 3'd7, 32'h0000_00E7);
        cfg(CFG_PERIOD, 3'd7, 32'd1);
        tx_full = 1'b1;
        enable = 1'b1; c0 = cyc;
        goto(c0 + 12);
        cfg(CFG_PERIOD, 3'd7, 32'd0);
        goto(c0 + 22);
        tx_full = 1'b0;
        goto(c0 + 40);
        chk("t5_no_overrun", 32'(overrun), 32'd0);
        enable = 1'b0;
        drained("t5_drained");

        // 6a: reset during ISSUE
        do_reset();
        cfg(CFG_WORD, 3'd0, 32'h0000_00F0);
        cfg(CFG_PERIOD, 3'd0, 32'd1);
        enable = 1'b1; c0 = cyc;
        expect_tx(32'h0000_00F0, c0 + 11);
        goto(c0 + 11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_rst_tx_wr", 32'(tx_wr), 32'd0);
        chk("t6_rst_tx_data", tx_data, 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        goto(c0 + 30);
        enable = 1'b0;
        drained("t6a_drained");

        // 6b: disable mid-countdown freezes it; re-enable resumes without an extra send
        do_reset();
        cfg(CFG_WORD, 3'd2, 32'h0000_00A2);
        cfg(CFG_PERIOD, 3'd2, 32'd3);
        enable = 1'b1; c0 = cyc;
        goto(c0 + 22);
        enable = 1'b0;
        goto(c0 + 60);
        enable = 1'b1; c1 = cyc;
        expect_tx(32'h0000_00A2, c1 + 11);
        expect_tx(32'h0000_00A2, c1 + 41);
        goto(c1 + 45);
        enable = 1'b0;
        goto(c1 + 50);
        drained("t6b_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
